// File: rtl/bank_fill_arbiter.sv
// Round-robin arbiter that fills one whole 1024-word bank of a 16K x 8 memory with a producer's sample.
// Optional done/done_bank outputs are compiled in when BANK_FILL_DONE_EN is defined.
module bank_fill_arbiter #(
  parameter int NREQ  = 4,
  parameter int CICLI = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   dav_,
  output logic [NREQ-1:0]   rfd,
  input  logic [4*NREQ-1:0] enne,
  input  logic [8*NREQ-1:0] d7_d0,
  output logic [13:0]       a13_a0,
  output logic [7:0]        mem_d,
  output logic              mem_we_,
  output logic              busy,
  output logic [2:0]        gnt
`ifdef BANK_FILL_DONE_EN
  ,
  output logic [NREQ-1:0]   done,
  output logic [3:0]        done_bank
`endif
);

  localparam int CW = $clog2(CICLI);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      bank_arr [NREQ];
  logic [7:0]      data_arr [NREQ];
  logic [IW-1:0]   last_reg;
  logic [IW-1:0]   gnt_reg;
  logic [IW-1:0]   win_idx;
  logic            win_valid;
  logic [NREQ-1:0] rfd_reg;
  logic            mem_we_reg;
  logic [7:0]      sample_reg;
  logic [3:0]      bank_reg;
  logic [CW-1:0]   offset_reg;
  logic            last_word;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign bank_arr[gi] = enne[4*gi +: 4];
      assign data_arr[gi] = d7_d0[8*gi +: 8];
    end
  endgenerate

  // First requester after last_reg, wrapping modulo NREQ.
  always_comb begin
    logic [3:0] cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = 4'(last_reg) + 4'(k);
      if (cand >= 4'(NREQ)) begin
        cand = cand - 4'(NREQ);
      end
      if (!win_valid && !dav_[cand[IW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  // The word offset inside the bank doubles as the burst counter, so no carry can leave the bank.
  assign last_word = (offset_reg == CW'(CICLI - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_valid)      state_next = ACK;
      ACK:     if (dav_[gnt_reg])  state_next = WRITE;
      WRITE:   if (last_word)      state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rfd_reg    <= '1;
      mem_we_reg <= 1'b1;
      sample_reg <= '0;
      bank_reg   <= '0;
      offset_reg <= '0;
      gnt_reg    <= '0;
      last_reg   <= IW'(NREQ - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            sample_reg       <= data_arr[win_idx];
            bank_reg         <= bank_arr[win_idx];
            offset_reg       <= '0;
            rfd_reg[win_idx] <= 1'b0;
            gnt_reg          <= win_idx;
            last_reg         <= win_idx;
          end
        end
        ACK: begin
          if (dav_[gnt_reg]) begin
            mem_we_reg <= 1'b0;
          end
        end
        WRITE: begin
          if (last_word) begin
            mem_we_reg       <= 1'b1;
            rfd_reg[gnt_reg] <= 1'b1;
          end else begin
            offset_reg <= offset_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BANK_FILL_DONE_EN
  logic [NREQ-1:0] done_reg;
  logic [3:0]      done_bank_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_reg      <= '0;
      done_bank_reg <= '0;
    end else begin
      done_reg <= '0;
      if (state_reg == WRITE && last_word) begin
        done_reg[gnt_reg] <= 1'b1;
        done_bank_reg     <= bank_reg;
      end
    end
  end

  assign done      = done_reg;
  assign done_bank = done_bank_reg;
`endif

  assign rfd     = rfd_reg;
  assign a13_a0  = {bank_reg, offset_reg};
  assign mem_d   = sample_reg;
  assign mem_we_ = mem_we_reg;
  assign busy    = (state_reg != IDLE);
  assign gnt     = 3'(gnt_reg);

endmodule

// File: tb/tb_bank_fill_arbiter.sv
// Self-checking bench for bank_fill_arbiter: per-cycle model comparison plus directed burst checks.
`timescale 1ns/1ps
module tb_bank_fill_arbiter;
  localparam int NREQ = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   dav_  = '1;
  logic [NREQ-1:0]   rfd;
  logic [4*NREQ-1:0] enne  = '0;
  logic [8*NREQ-1:0] d7_d0 = '0;
  logic [13:0]       a13_a0;
  logic [7:0]        mem_d;
  logic              mem_we_;
  logic              busy;
  logic [2:0]        gnt;
`ifdef BANK_FILL_DONE_EN
  logic [NREQ-1:0]   done;
  logic [3:0]        done_bank;
`endif

  int checks = 0;
  int errors = 0;

  bank_fill_arbiter #(.NREQ(NREQ), .CICLI(1024)) dut (
    .clock   (clock),
    .reset   (reset),
    .dav_    (dav_),
    .rfd     (rfd),
    .enne    (enne),
    .d7_d0   (d7_d0),
    .a13_a0  (a13_a0),
    .mem_d   (mem_d),
    .mem_we_ (mem_we_),
    .busy    (busy),
    .gnt     (gnt)
`ifdef BANK_FILL_DONE_EN
    ,
    .done      (done),
    .done_bank (done_bank)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 waiting for dav_ release, 2 filling.
  int              m_phase, m_w, m_last, m_gnt, m_written, m_bank, m_data, m_found, m_c;
  int              m_addr, m_done_bank;
  logic [NREQ-1:0] m_rfd, m_done;
  bit              model_ok = 1'b0;
  int              grant_log[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_last = NREQ - 1; m_gnt = 0; m_addr = 0; m_rfd = '1;
      m_data = 0; m_done = '0; m_done_bank = 0; model_ok = 1'b1;
    end else begin
      m_done = '0;
      case (m_phase)
        0: begin
          m_found = -1;
          for (int k = 1; k <= NREQ; k++) begin
            m_c = (m_last + k) % NREQ;
            if (m_found < 0 && dav_[m_c] == 1'b0) m_found = m_c;
          end
          if (m_found >= 0) begin
            m_w = m_found; m_gnt = m_found; m_last = m_found;
            m_bank = int'(enne[4*m_found +: 4]);
            m_data = int'(d7_d0[8*m_found +: 8]);
            m_addr = m_bank * 1024; m_written = 0;
            m_rfd[m_found] = 1'b0; m_phase = 1;
            grant_log.push_back(m_found);
          end
        end
        1: if (dav_[m_w] == 1'b1) m_phase = 2;
        default: begin
          m_written++;
          if (m_written == 1024) begin
            m_phase = 0; m_rfd[m_w] = 1'b1;
            m_done[m_w] = 1'b1; m_done_bank = m_bank;
          end else begin
            m_addr = m_addr + 1;
          end
        end
      endcase
    end
  end

  always @(negedge clock) begin
    if (!reset && model_ok) begin
      check("rfd", 32'(rfd), 32'(m_rfd));
      check("mem_we_", 32'(mem_we_), (m_phase == 2) ? 0 : 1);
      check("busy", 32'(busy), (m_phase != 0) ? 1 : 0);
      check("gnt", 32'(gnt), m_gnt);
      check("a13_a0", 32'(a13_a0), m_addr);
      if (m_phase == 2) check("mem_d", 32'(mem_d), m_data);
`ifdef BANK_FILL_DONE_EN
      check("done", 32'(done), 32'(m_done));
      check("done_bank", 32'(done_bank), m_done_bank);
`endif
    end
  end

  // Burst monitor: one record and one printed line per strobed burst.
  typedef struct { int cnt; int first; int last; int data; int g; bit bad; } burst_t;
  burst_t bursts[$];
  burst_t mon_rec;
  int     cur_cnt = 0;

  always @(negedge clock) begin
    if (mem_we_ === 1'b0) begin
      if (cur_cnt == 0) begin
        mon_rec.first = int'(a13_a0); mon_rec.data = int'(mem_d);
        mon_rec.g = int'(gnt); mon_rec.bad = 1'b0;
      end else if (int'(a13_a0) != mon_rec.last + 1 || int'(mem_d) != mon_rec.data) begin
        mon_rec.bad = 1'b1;
      end
      mon_rec.last = int'(a13_a0);
      cur_cnt++;
    end else if (cur_cnt > 0) begin
      mon_rec.cnt = cur_cnt;
      bursts.push_back(mon_rec);
      $display("burst gnt=%0d words=%0d addr=%04h..%04h data=%02h gaps=%0d",
               mon_rec.g, mon_rec.cnt, mon_rec.first, mon_rec.last, mon_rec.data, mon_rec.bad);
      cur_cnt = 0;
    end
  end

`ifdef BANK_FILL_DONE_EN
  typedef struct { int d; int b; } done_t;
  done_t done_log[$];
  done_t done_rec;
  always @(negedge clock) begin
    if (!reset && done !== '0) begin
      done_rec.d = int'(done); done_rec.b = int'(done_bank);
      done_log.push_back(done_rec);
    end
  end
`endif

  task automatic request(input int i, input logic [3:0] b, input logic [7:0] d);
    int n;
    @(negedge clock);
    enne[4*i +: 4]  = b;
    d7_d0[8*i +: 8] = d;
    dav_[i]         = 1'b0;
    n = 0;
    while (rfd[i] !== 1'b0 && n < 5000) begin @(negedge clock); n++; end
    check($sformatf("rfd%0d_fall", i), 32'(rfd[i]), 0);
    dav_[i] = 1'b1;
    n = 0;
    while (rfd[i] !== 1'b1 && n < 2000) begin @(negedge clock); n++; end
    check($sformatf("rfd%0d_rise", i), 32'(rfd[i]), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rfd"}, 32'(rfd), 32'hF);
    check({tag, "_mem_we_"}, 32'(mem_we_), 1);
    check({tag, "_a13_a0"}, 32'(a13_a0), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_gnt"}, 32'(gnt), 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clock);
    #3 reset = 1'b1;
    #1 check_reset_vals(tag);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
    #1;
  endtask

  task automatic check_burst(input string tag, input int idx, input int g, input int first,
                             input int last, input int data, input int cnt);
    if (idx >= bursts.size()) begin
      checks++; errors++;
      $display("FAIL %s_missing: got %0d bursts required %0d", tag, bursts.size(), idx + 1);
      return;
    end
    check({tag, "_gnt"}, bursts[idx].g, g);
    check({tag, "_first"}, bursts[idx].first, first);
    check({tag, "_last"}, bursts[idx].last, last);
    check({tag, "_data"}, bursts[idx].data, data);
    check({tag, "_words"}, bursts[idx].cnt, cnt);
    check({tag, "_gaps"}, 32'(bursts[idx].bad), 0);
  endtask

  initial begin
    int base;
    int n;
    int exp_order[5];
    exp_order = '{0, 2, 3, 0, 3};

    #2 reset = 1'b1;
    #1 check_reset_vals("por");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Single fill of bank 3.
    base = bursts.size();
    request(1, 4'd3, 8'hA5);
    settle();
    check_burst("single", base, 1, 'h0C00, 'h0FFF, 'hA5, 1024);

    // Round-robin from a fresh pointer.
    do_reset("rr_reset");
    base = bursts.size();
    n    = grant_log.size();
    fork
      request(0, 4'd1, 8'h10);
      request(2, 4'd4, 8'h42);
      request(3, 4'd7, 8'h73);
    join
    fork
      request(0, 4'd8, 8'h08);
      request(3, 4'd9, 8'h39);
    join
    settle();
    check("rr_grants", grant_log.size() - n, 5);
    for (int k = 0; k < 5; k++) begin
      if (n + k < grant_log.size()) check($sformatf("rr_order%0d", k), grant_log[n + k], exp_order[k]);
    end
    check_burst("rr0", base,     0, 'h0400, 'h07FF, 'h10, 1024);
    check_burst("rr1", base + 1, 2, 'h1000, 'h13FF, 'h42, 1024);
    check_burst("rr2", base + 2, 3, 'h1C00, 'h1FFF, 'h73, 1024);
    check_burst("rr3", base + 3, 0, 'h2000, 'h23FF, 'h08, 1024);
    check_burst("rr4", base + 4, 3, 'h2400, 'h27FF, 'h39, 1024);

    // Reset during the 500th strobe of a bank-10 fill.
    base = bursts.size();
    fork
      request(1, 4'd10, 8'h5A);
    join_none
    n = 0;
    while (mem_we_ !== 1'b0 && n < 300) begin @(negedge clock); n++; end
    check("mid_first_addr", 32'(a13_a0), 'h2800);
    repeat (499) @(negedge clock);
    check("mid_500_addr", 32'(a13_a0), 'h29F3);
    check("mid_500_we", 32'(mem_we_), 0);
    #1 reset = 1'b1;
    #1 check_reset_vals("mid");
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    settle();
    check_burst("aborted", base, 1, 'h2800, 'h29F3, 'h5A, 500);

    base = bursts.size();
    request(1, 4'd2, 8'h77);
    settle();
    check_burst("refill", base, 1, 'h0800, 'h0BFF, 'h77, 1024);

    // Top bank: last strobe at 0x3FFF, then no further strobe.
    base = bursts.size();
    request(2, 4'd15, 8'h3C);
    settle();
    check_burst("bank15", base, 2, 'h3C00, 'h3FFF, 'h3C, 1024);
    check("bank15_idle_we", 32'(mem_we_), 1);
    check("bank15_hold_addr", 32'(a13_a0), 'h3FFF);
    check("bank15_bursts", bursts.size() - base, 1);

`ifdef BANK_FILL_DONE_EN
    done_log.delete();
    fork
      request(0, 4'd5, 8'h55);
      request(1, 4'd6, 8'h66);
    join
    settle();
    check("done_pulses", done_log.size(), 2);
    if (done_log.size() >= 2) begin
      check("done0_vec", done_log[0].d, 1);
      check("done0_bank", done_log[0].b, 5);
      check("done1_vec", done_log[1].d, 2);
      check("done1_bank", done_log[1].b, 6);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout at %0t required completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bank_fill_arbiter.md
Name:
bank_fill_arbiter

Overview:
- Shares one 16K x 8 sample memory (14-bit address, 16 banks of 1024 words) between NREQ producers.
- Each producer offers one 8-bit sample plus a 4-bit bank number over a dav_/rfd handshake.
- The block grants producers round-robin, accepts the winner's sample, then writes it to all 1024 words of the selected bank.
- Sits between the producer front-ends and the memory write port. It is the only master of that port.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- CICLI, 1024, words per bank; fixed, so bank base = enne*CICLI and address width = 14.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dav_  in  NREQ  per-requester data-valid, active-low.
- rfd  out  NREQ  per-requester ready-for-data, active-high.
- enne  in  4*NREQ  bank number of requester i in bits [4i+3:4i].
- d7_d0  in  8*NREQ  sample of requester i in bits [8i+7:8i].
- a13_a0  out  14  memory write address.
- mem_d  out  8  memory write data.
- mem_we_  out  1  memory write strobe, active-low, one word per clock while low.
- busy  out  1  high in ACK and WRITE.
- gnt  out  3  index of current or last granted requester.

Behaviour:
- Reset (async, while reset=1):
  - FSM=IDLE, rfd=all 1, mem_we_=1.
  - a13_a0=0, mem_d=0, busy=0, gnt=0.
  - RR pointer last=NREQ-1, so requester 0 has top priority first.
  - Sample register, bank register and COUNT are cleared.
- Handshake, requester side:
  - Producer drives data and bank, pulls dav_ low, waits for rfd=0.
  - Producer then raises dav_ and waits for rfd=1 before the next request.
  - rfd[i]=1 means "your sample is not yet accepted".
- IDLE:
  - mem_we_=1, busy=0.
  - Candidates are all i with dav_[i]=0; the winner is the first candidate after last, wrapping modulo NREQ.
  - If there is a winner, on the next edge:
    - capture sample and enne of the winner;
    - a13_a0 <= enne_w*1024;
    - rfd[w] <= 0, gnt <= w, last <= w;
    - go to ACK.
  - Losers keep rfd=1 and remain pending.
- ACK:
  - Wait for dav_[w]=1, then go to WRITE.
  - Changes on the winner's enne or d7_d0 are ignored; the captured values are used.
  - Other requesters are ignored.
- WRITE:
  - mem_we_=0, mem_d=captured sample, COUNT counts 1023 down to 0.
  - Each clock a13_a0 increments by 1.
  - Exactly 1024 consecutive strobed words: base..base+1023.
  - On the COUNT=0 edge:
    - mem_we_ <= 1, rfd[w] <= 1;
    - a13_a0 holds the last address;
    - go to IDLE.
- Address: bank 15 covers 0x3C00..0x3FFF. No carry leaves the bank and no 14-bit wrap ever occurs.
- Latency:
  - dav_ low sampled in IDLE -> rfd low 1 clock later.
  - dav_ high sampled in ACK -> first strobed word the next cycle.
  - At least 1 IDLE cycle between bursts.
- Simultaneous requests: strict round-robin. No requester is granted twice while another candidate is pending.
- A winner whose dav_ is already high on the grant edge still passes through ACK for 1 cycle.
- Reset mid-burst: the burst is aborted immediately and mem_we_ goes to 1 asynchronously. All rfd return to 1, so the interrupted producer must re-request.

Optional Feature:
- Macro: BANK_FILL_DONE_EN.
- Defined:
  - adds output done [NREQ-1:0], reset 0;
  - done[w] pulses high for exactly 1 clock, in the first IDLE cycle after the last strobed word of requester w's burst;
  - adds output done_bank [3:0] holding the bank just filled.
- Undefined: both ports are absent and there is no extra logic.

Test Plan:
- Reset check: assert reset mid-clock -> outputs immediately rfd=4'b1111, mem_we_=1, a13_a0=0, busy=0, gnt=0.
- Single fill:
  - Stimulus: req1 with enne=3, data=0xA5, dav_[1]=0.
  - Required: rfd[1]=0 after 1 clock, then hold for dav_[1]=1.
  - Required: 1024 strobes at 0x0C00..0x0FFF, all with data 0xA5.
  - Required: rfd[1]=1 after the last strobe and no other rfd changes.
- Round-robin:
  - Stimulus: req0, req2, req3 all low at once after reset.
  - Required: grant order 0, 2, 3.
  - Then req0 and req3 low again with last=3 -> req0 is granted first.
- Bank 15 boundary: enne=15, data=0x3C -> last strobe at a13_a0=0x3FFF, then IDLE with no extra strobe.
- Reset mid-burst: assert reset at the 500th strobe -> mem_we_=1 asynchronously, state IDLE; a re-request with enne=2 writes 0x0800..0x0BFF in full.
- BANK_FILL_DONE_EN: two back-to-back fills (req0 enne=5, req1 enne=6) -> done[0] and done[1] pulse 1 clock each, with done_bank=5 and 6 respectively.
